// File: rtl/im_loader.sv
// Byte-stream program loader: deframes A5/LEN/data/SUM images into big-endian
// 32-bit words and writes them to the instruction memory from BASE_ADDR upward.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_SUM, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [1:0]  bidx;
  logic [23:0] acc;
  logic [7:0]  csum;
  logic        take;
  logic [15:0] len_full;

  // The write beat is the only cycle without ready, giving the one-cycle bubble.
  assign rx_ready = ~im_we;
  assign take     = rx_valid && rx_ready;
  assign len_full = {n_words[15:8], rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      n_words  <= '0;
      idx      <= '0;
      bidx     <= '0;
      acc      <= '0;
      csum     <= '0;
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (take && rx_data == 8'hA5) begin
            state    <= S_LEN_HI;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= '0;
            csum     <= '0;
            busy     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (take) begin
            n_words[15:8] <= rx_data;
            state         <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (take) begin
            n_words <= len_full;
            idx     <= '0;
            bidx    <= '0;
            if ({16'd0, len_full} > MAX_WORDS) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'd1;
              busy     <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= S_SUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            csum <= csum + rx_data;
            bidx <= bidx + 2'd1;
            acc  <= {acc[15:0], rx_data};
            if (bidx == 2'd3) begin
              im_we    <= 1'b1;
              im_wdata <= {acc, rx_data};
              im_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          idx   <= idx + 16'd1;
          state <= (idx + 16'd1 == n_words) ? S_SUM : S_DATA;
        end
        S_SUM: begin
          if (take) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error    <= 1'b1;
              err_code <= 2'd2;
              state    <= S_ERR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: table of whole frames with expected writes and
// status, plus sequences for cadence, stalls, max length and async reset.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  im_loader #(.BASE_ADDR(32'h0000_3000), .MAX_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture writes; ready must be low exactly on the write beat.
  always @(negedge clk) begin
    cyc++;
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
      wc.push_back(cyc);
    end
    if (rst_n) begin
      tests++;
      if (rx_ready !== ~im_we) begin
        fails++;
        $display("FAIL ready_vs_we: ready %b we %b expected ready %b", rx_ready, im_we, ~im_we);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int maxgap);
    int t;
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 10 cycles");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] bytes, input int n, input int maxgap);
    for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8], maxgap);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           n;
    int           nw;
    logic [31:0]  a0, d0, a1, d1;
    logic         exp_done;
    logic         exp_err;
    logic [1:0]   exp_code;
  } vec_t;

  vec_t v[6];

  logic [127:0] f3 = 128'hA5_00_03_01020304_05060708_090A0B0C_4E;

  initial begin
    v[0] = '{"good2", 128'hA5_00_02_24010005_0000000C_36, 12, 2,
             32'h3000, 32'h24010005, 32'h3004, 32'h0000000C, 1'b1, 1'b0, 2'd0};
    v[1] = '{"badsum", 128'hA5_00_02_24010005_0000000C_37, 12, 2,
             32'h3000, 32'h24010005, 32'h3004, 32'h0000000C, 1'b0, 1'b1, 2'd2};
    v[2] = '{"toolong", 128'hA5_08_01_11_22, 5, 0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd1};
    v[3] = '{"empty", 128'hA5_00_00_00, 4, 0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0};
    v[4] = '{"junk1w", 128'h3C_12_A5_00_01_DEADBEEF_38, 10, 1,
             32'h3000, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0};
    v[5] = '{"a5data", 128'hA5_00_01_A5A5A5A5_94, 8, 1,
             32'h3000, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0};

    #12;
    chk("rst_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_status", {28'd0, busy, done, error, 1'b0} | {30'd0, err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      wa.delete(); wd.delete(); wc.delete();
      send_bytes(v[i].bytes, v[i].n, 0);
      chk({v[i].name, "_nw"}, wa.size(), v[i].nw);
      if (wa.size() > 0) begin
        chk({v[i].name, "_a0"}, wa[0], v[i].a0);
        chk({v[i].name, "_d0"}, wd[0], v[i].d0);
      end
      if (wa.size() > 1) begin
        chk({v[i].name, "_a1"}, wa[1], v[i].a1);
        chk({v[i].name, "_d1"}, wd[1], v[i].d1);
      end
      chk({v[i].name, "_done"}, {31'd0, done}, {31'd0, v[i].exp_done});
      chk({v[i].name, "_err"}, {31'd0, error}, {31'd0, v[i].exp_err});
      chk({v[i].name, "_code"}, {30'd0, err_code}, {30'd0, v[i].exp_code});
      chk({v[i].name, "_busy"}, {31'd0, busy}, 32'd0);
    end

    // Sync clears sticky done and raises busy; empty frame restores done.
    send(8'hA5, 0);
    chk("sync_done_clr", {31'd0, done}, 32'd0);
    chk("sync_busy", {31'd0, busy}, 32'd1);
    send_bytes(128'h00_00_00, 3, 0);
    chk("empty2_done", {31'd0, done}, 32'd1);

    // Continuous valid over 3 words: writes every 5 cycles.
    wa.delete(); wd.delete(); wc.delete();
    send_bytes(f3, 16, 0);
    chk("cad_nw", wa.size(), 3);
    for (int k = 0; k < 3 && k < wa.size(); k++) begin
      chk("cad_addr", wa[k], 32'h3000 + 32'(4 * k));
      chk("cad_data", wd[k], {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
    end
    for (int k = 1; k < wc.size(); k++) chk("cad_gap", wc[k] - wc[k-1], 5);
    chk("cad_done", {31'd0, done}, 32'd1);

    // Random valid gaps give identical writes.
    wa.delete(); wd.delete(); wc.delete();
    send_bytes(f3, 16, 3);
    chk("gap_nw", wa.size(), 3);
    for (int k = 0; k < 3 && k < wa.size(); k++) begin
      chk("gap_addr", wa[k], 32'h3000 + 32'(4 * k));
      chk("gap_data", wd[k], {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
    end
    chk("gap_done", {31'd0, done}, 32'd1);

    // Maximum legal length: 2048 zero words, last address 0x4FFC.
    wa.delete(); wd.delete(); wc.delete();
    send(8'hA5, 0); send(8'h08, 0); send(8'h00, 0);
    for (int k = 0; k < 4 * 2048; k++) send(8'h00, 0);
    send(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("max_nw", wa.size(), 2048);
    if (wa.size() == 2048) chk("max_last", wa[2047], 32'h4FFC);
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_err", {31'd0, error}, 32'd0);

    // Reload a nonzero word so reset visibly clears wdata.
    send_bytes(128'hA5_00_01_DEADBEEF_38, 8, 0);

    // Async reset after two data bytes.
    wa.delete(); wd.delete(); wc.delete();
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h11, 0); send(8'h22, 0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, rx_ready}, 32'd1);
    chk("arst_we", {31'd0, im_we}, 32'd0);
    chk("arst_addr", im_addr, 32'h3000);
    chk("arst_wdata", im_wdata, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {30'd0, error, 1'b0} | {30'd0, err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_bytes(v[0].bytes, v[0].n, 0);
    chk("post_nw", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("post_a0", wa[0], 32'h3000);
      chk("post_d0", wd[0], 32'h24010005);
      chk("post_a1", wa[1], 32'h3004);
      chk("post_d1", wd[1], 32'h0000000C);
    end
    chk("post_done", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the instruction memory.
- Receives a framed program image over an 8-bit valid/ready stream, assembles big-endian 32-bit words, and drives the instruction-memory write port at sequential word addresses from BASE_ADDR.
- Flags completion or error. Holds the CPU via busy while a frame is in progress.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address written by word 0.
- MAX_WORDS, 2048, capacity of the instruction memory in words (byte window 0x3000..0x4FFF).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader accepts a byte this cycle; a byte is consumed when rx_valid && rx_ready.
- im_we  output  1  one-cycle write strobe to the instruction memory.
- im_addr  output  32  byte address of the write (word aligned).
- im_wdata  output  32  instruction word to write.
- busy  output  1  frame in progress; CPU must be held.
- done  output  1  last frame loaded correctly; sticky.
- error  output  1  last frame failed; sticky.
- err_code  output  2  error cause: 0 none, 1 length > MAX_WORDS, 2 checksum mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - rx_ready=1; im_we=0; im_addr=BASE_ADDR; im_wdata=0.
  - busy=0; done=0; error=0; err_code=0.
  - Word count, byte index and checksum all 0.
  - Reset mid-frame abandons the frame; memory already written is not restored.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO, then N=LEN words of 4 bytes each (MSB first), then SUM.
  - SUM is the 8-bit modulo-256 sum of all data bytes only; header bytes are excluded.
- States:
  - IDLE/DONE/ERR: accepted bytes other than 0xA5 are discarded.
    - 0xA5 -> LEN_HI. Clears done, error, err_code and checksum; sets busy=1.
  - LEN_HI: accepted byte -> N[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte -> N[7:0], then:
    - N > MAX_WORDS -> ERR with err_code=1;
    - N == 0 -> SUM;
    - else -> DATA with word index 0.
  - DATA: shift each accepted byte into the word assembler and add it to the checksum.
    - On the 4th byte, the next cycle has im_we=1, im_wdata=the assembled word, im_addr=BASE_ADDR + 4*index.
    - After the write, index increments; after word N-1, go to SUM.
  - SUM: accepted byte is compared with the checksum.
    - Equal -> DONE (done=1).
    - Else -> ERR (error=1, err_code=2).
  - DONE/ERR: busy=0. Status holds until the next 0xA5.
- Handshake:
  - rx_ready=1 in every cycle except the cycle where im_we=1, so the write beat is a one-cycle bubble.
  - With continuous rx_valid, one word is written every 5 cycles.
  - rx_valid low simply stalls the FSM; no timeout.
- im_we is asserted exactly once per word and never outside DATA.
- im_addr and im_wdata hold their last value when im_we=0.
- Address arithmetic is 32-bit unsigned.
- N == MAX_WORDS is legal; the last address is BASE_ADDR + 4*(MAX_WORDS-1) = 0x4FFC.
- Checksum wraps modulo 256.
- 0xA5 appearing inside LEN/DATA/SUM is ordinary data; there is no resync mid-frame.

Test Plan:
- Reset then frame A5 00 02 | 24 01 00 05 | 00 00 00 0C | 36 -> im_we pulses twice: (0x3000, 0x24010005) then (0x3004, 0x0000000C); done=1, busy=0, error=0.
- Same frame with SUM=0x37 -> both writes still occur; error=1, err_code=2, done=0.
- Header A5 08 01 (N=2049) -> no im_we; error=1, err_code=1; the subsequent bytes 11 22 are discarded while in ERR.
- A5 00 00 00 -> done=1, no writes. Then junk 3C 12 followed by a valid 1-word frame -> done is cleared on A5 and set again at the end; junk never writes.
- Continuous rx_valid over a 3-word frame -> rx_ready low exactly on each im_we cycle; 5-cycle word cadence. Random rx_valid gaps -> identical writes.
- Drop rst_n mid-DATA after 2 bytes -> all outputs return to reset values asynchronously. A new full frame then loads correctly from 0x3000.
